// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Front end of the code lock: scans a 4x3 active-low matrix keypad,
//   debounces press and release, and encodes the key into the lock's
//   4-bit code ('0'-'9' = 0..9, '#' = 10, '*' = 11).
//
//   Optional feature macro: KEYPAD_AUTOREPEAT_EN
//     When defined, a held key re-strobes Valid_1 after REPEAT_DLY clocks
//     and then every REPEAT_PER clocks. When undefined, one strobe per press.
//
// Ports
//   clk      in   system clock, rising edge
//   reset_1  in   synchronous reset, active high
//   row_in   in   [3:0] keypad rows, active low, asynchronous
//   col_out  out  [2:0] column drive, active low, one-hot-zero
//   Code_1   out  [3:0] last confirmed key code
//   Valid_1  out  one-cycle strobe per confirmed key (and per repeat)
//   S_Row    out  high while the confirmed key is held
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CYC = 20000,
  parameter int REPEAT_DLY   = 500000,
  parameter int REPEAT_PER   = 100000
) (
  input  logic       clk,
  input  logic       reset_1,
  input  logic [3:0] row_in,
  output logic [2:0] col_out,
  output logic [3:0] Code_1,
  output logic       Valid_1,
  output logic       S_Row
);

  localparam int CMAX = (SCAN_DIV > DEBOUNCE_CYC) ? SCAN_DIV : DEBOUNCE_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  if (SCAN_DIV < 2 || DEBOUNCE_CYC < 1 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_param
    $error("keypad_scanner: parameter out of range");
  end

  typedef enum logic [1:0] {SCAN, DEB_PRESS, PRESSED, DEB_REL} state_t;

  state_t          state;
  logic [3:0]      rs_meta, rs;   // row synchroniser
  logic [3:0]      pat;           // row pattern latched at the scan sample
  logic [1:0]      col_idx;
  logic [CW-1:0]   cnt;           // dwell / debounce counter
  logic            load_pend;     // debounce succeeded: load code next cycle
  logic            val_pend;      // strobe Valid_1 next cycle

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int HW   = $clog2(RMAX + 1);
  logic [HW-1:0]   hold_cnt;
  logic            rep_phase;     // 0: waiting first repeat, 1: periodic
`endif

  logic [3:0] low;
  logic       one_low;
  logic [1:0] row_idx;
  logic [1:0] col_nxt;
  logic [3:0] key_code;

  // Exactly one row pulled low: any two or more is a ghost/multi-key.
  assign low     = ~rs;
  assign one_low = (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
  assign col_nxt = (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;

  always_comb begin
    row_idx = 2'd0;
    case (pat)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  // Rows 0-2 hold digits 1-9 in reading order; row 3 is '*', '0', '#'.
  always_comb begin
    key_code = 4'd0;
    if (row_idx == 2'd3) begin
      case (col_idx)
        2'd0:    key_code = 4'b1011;
        2'd1:    key_code = 4'b0000;
        default: key_code = 4'b1010;
      endcase
    end else begin
      key_code = 4'({2'b00, row_idx} * 4'd3 + {2'b00, col_idx} + 4'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_1) begin
      state     <= SCAN;
      rs_meta   <= 4'hF;
      rs        <= 4'hF;
      pat       <= 4'hF;
      col_idx   <= 2'd0;
      col_out   <= 3'b110;
      cnt       <= '0;
      load_pend <= 1'b0;
      val_pend  <= 1'b0;
      Code_1    <= 4'b0000;
      Valid_1   <= 1'b0;
      S_Row     <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      hold_cnt  <= '0;
      rep_phase <= 1'b0;
`endif
    end else begin
      rs_meta  <= row_in;
      rs       <= rs_meta;
      Valid_1  <= val_pend;
      val_pend <= 1'b0;

      // Code and S_Row settle one cycle ahead of the strobe.
      if (load_pend) begin
        Code_1    <= key_code;
        S_Row     <= 1'b1;
        load_pend <= 1'b0;
        val_pend  <= 1'b1;
      end

      case (state)
        SCAN: begin
          if (cnt == CW'(SCAN_DIV - 1)) begin
            cnt <= '0;
            if (one_low) begin
              pat   <= rs;
              state <= DEB_PRESS;
            end else begin
              col_idx <= col_nxt;
              col_out <= ~(3'b001 << col_nxt);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DEB_PRESS: begin
          if (rs != pat) begin
            state   <= SCAN;
            cnt     <= '0;
            col_idx <= col_nxt;
            col_out <= ~(3'b001 << col_nxt);
          end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
            state     <= PRESSED;
            cnt       <= '0;
            load_pend <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PRESSED: begin
          if (rs == 4'hF) begin
            state <= DEB_REL;
            cnt   <= '0;
          end
        end
        DEB_REL: begin
          if (rs != 4'hF) begin
            state <= PRESSED;     // release bounce: key still held
            cnt   <= '0;
          end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
            state   <= SCAN;
            cnt     <= '0;
            S_Row   <= 1'b0;
            col_idx <= col_nxt;
            col_out <= ~(3'b001 << col_nxt);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= SCAN;
      endcase

`ifdef KEYPAD_AUTOREPEAT_EN
      // Hold timer is zeroed at confirmation, runs only while PRESSED.
      if (load_pend) begin
        hold_cnt  <= '0;
        rep_phase <= 1'b0;
      end else if (state == PRESSED) begin
        if (hold_cnt == (rep_phase ? HW'(REPEAT_PER - 1) : HW'(REPEAT_DLY - 1))) begin
          hold_cnt  <= '0;
          rep_phase <= 1'b1;
          val_pend  <= 1'b1;
        end else begin
          hold_cnt <= hold_cnt + HW'(1);
        end
      end else begin
        hold_cnt  <= '0;
        rep_phase <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model turns pressed keys plus the
// column drive into row levels; expected codes come from the printed key
// layout, timings from the scan/debounce rules.
module tb_keypad_scanner;
  localparam int SD = 4, DB = 8, RD = 40, RP = 10;

  logic       clk = 1'b0;
  logic       reset_1;
  logic [3:0] row_in;
  logic [2:0] col_out;
  logic [3:0] Code_1;
  logic       Valid_1;
  logic       S_Row;

  logic [3:0][2:0] keys;

  int errors = 0, checks = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  logic [3:0] pulse_code = 4'd0;
  int pulse_cyc[$];
  int code_unstable = 0, wide_pulse = 0, valid_in_reset = 0;
  logic prev_valid = 1'b0;
  logic [3:0] prev_code = 4'd0;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYC(DB), .REPEAT_DLY(RD), .REPEAT_PER(RP)) dut (
    .clk(clk), .reset_1(reset_1), .row_in(row_in), .col_out(col_out),
    .Code_1(Code_1), .Valid_1(Valid_1), .S_Row(S_Row)
  );

  // Keypad: a row is pulled low when a pressed key sits in a driven column.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (keys[r][c] && !col_out[c]) row_in[r] = 1'b0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (Valid_1 === 1'b1) begin
      pulse_cnt = pulse_cnt + 1;
      pulse_code = Code_1;
      pulse_cyc.push_back(cyc);
      if (prev_code !== Code_1) code_unstable = code_unstable + 1;
      if (prev_valid === 1'b1) wide_pulse = wide_pulse + 1;
      if (reset_1 === 1'b1) valid_in_reset = valid_in_reset + 1;
    end
    prev_valid = Valid_1;
    prev_code  = Code_1;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  function automatic logic [3:0] ref_code(input int r, input int c);
    string km = "123456789*0#";
    byte ch;
    ch = km[r * 3 + c];
    if (ch == "#") return 4'd10;
    if (ch == "*") return 4'd11;
    return 4'(ch - "0");
  endfunction

  task automatic wait_col(input logic [2:0] v, output bit ok);
    int n = 0;
    while (col_out !== v && n < 60) begin tick(); n++; end
    ok = (col_out === v);
  endtask

  task automatic wait_srow(input logic lvl, output int n);
    n = 0;
    while (S_Row !== lvl && n < 200) begin tick(); n++; end
    if (S_Row !== lvl) n = -1;
  endtask

  // Press (optionally bouncing), hold, release (optionally bouncing).
  task automatic do_press(input int r, input int c, input bit bnc, input int hold,
                          output int t_rise, output int t_fall);
    if (bnc) for (int i = 0; i < 5; i++) begin keys[r][c] = 1'($urandom_range(0, 1)); tick(); end
    keys[r][c] = 1'b1;
    wait_srow(1'b1, t_rise);
    tick(hold);
    if (bnc) for (int i = 0; i < 5; i++) begin keys[r][c] = 1'($urandom_range(0, 1)); tick(); end
    keys = '0;
    wait_srow(1'b0, t_fall);
    tick(4);
  endtask

  task automatic test_reset;
    logic [2:0] seq [3];
    seq[0] = 3'b110; seq[1] = 3'b101; seq[2] = 3'b011;
    keys = '0; reset_1 = 1'b1;
    tick(3);
    checks++; if (col_out !== 3'b110) begin errors++; $display("FAIL reset_col: got %b want 110", col_out); end
    checks++; if (Code_1 !== 4'd0) begin errors++; $display("FAIL reset_code: got %b want 0000", Code_1); end
    checks++; if (Valid_1 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", Valid_1); end
    checks++; if (S_Row !== 1'b0) begin errors++; $display("FAIL reset_srow: got %b want 0", S_Row); end
    reset_1 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) tick();
      checks++;
      if (col_out !== seq[(k / SD) % 3]) begin
        errors++; $display("FAIL scan_col[%0d]: got %b want %b", k, col_out, seq[(k / SD) % 3]);
      end
    end
    checks++; if (pulse_cnt !== 0) begin errors++; $display("FAIL idle_pulses: got %0d want 0", pulse_cnt); end
  endtask

  task automatic test_hash;
    bit ok; int c0, p0, n, lowcnt;
    wait_col(3'b110, ok);
    checks++; if (!ok) begin errors++; $display("FAIL hash_wait_col0: col %b", col_out); end
    keys[3][2] = 1'b1;
    p0 = pulse_cnt;
    wait_col(3'b011, ok);
    c0 = cyc;
    checks++; if (!ok) begin errors++; $display("FAIL hash_wait_col2: col %b", col_out); end
    n = 0;
    while (pulse_cnt == p0 && n < 100) begin tick(); n++; end
    checks++;
    if (pulse_cnt == p0 || pulse_cyc[$] - c0 != SD + DB + 2) begin
      errors++; $display("FAIL hash_latency: got %0d want %0d", (pulse_cnt == p0) ? -1 : pulse_cyc[$] - c0, SD + DB + 2);
    end
    lowcnt = 0;
    for (int i = 0; i < 15; i++) begin tick(); if (S_Row !== 1'b1) lowcnt++; end
    checks++; if (lowcnt != 0) begin errors++; $display("FAIL hash_srow_hold: low %0d cycles want 0", lowcnt); end
    keys = '0;
    wait_srow(1'b0, n);
    checks++;
    if (n < DB || n > DB + 4) begin errors++; $display("FAIL hash_release: got %0d cycles want %0d..%0d", n, DB, DB + 4); end
    tick(4);
    checks++; if (pulse_code !== ref_code(3, 2)) begin errors++; $display("FAIL hash_code: got %b want %b", pulse_code, ref_code(3, 2)); end
    checks++; if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL hash_pulses: got %0d want 1", pulse_cnt - p0); end
    checks++; if (Code_1 !== 4'b1010) begin errors++; $display("FAIL hash_code_hold: got %b want 1010", Code_1); end
  endtask

  task automatic test_bounce;
    int p0, tr, tf;
    p0 = pulse_cnt;
    do_press(1, 1, 1'b1, 15, tr, tf);
    checks++; if (tr < 0 || tf < 0) begin errors++; $display("FAIL bounce_timeout: rise %0d fall %0d", tr, tf); end
    checks++; if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL bounce_pulses: got %0d want 1", pulse_cnt - p0); end
    checks++; if (pulse_code !== 4'b0101) begin errors++; $display("FAIL bounce_code: got %b want 0101", pulse_code); end
  endtask

  task automatic test_hold_star;
    int p0, n, bad;
    p0 = pulse_cnt; bad = 0;
    keys[3][0] = 1'b1;
    wait_srow(1'b1, n);
    checks++; if (n < 0) begin errors++; $display("FAIL star_rise: timeout"); end
    for (int i = 0; i < 100; i++) begin tick(); if (Code_1 !== 4'b1011) bad++; end
    keys = '0;
    wait_srow(1'b0, n);
    tick(4);
    checks++; if (bad != 0) begin errors++; $display("FAIL star_code: %0d cycles not 1011", bad); end
`ifdef KEYPAD_AUTOREPEAT_EN
    checks++; if (pulse_cnt - p0 < 6) begin errors++; $display("FAIL star_pulses: got %0d want >=6", pulse_cnt - p0); end
    bad = 0;
    for (int i = p0 + 1; i < pulse_cnt; i++)
      if (pulse_cyc[i] - pulse_cyc[i - 1] != ((i == p0 + 1) ? RD : RP)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL star_interval: %0d wrong gaps want 0", bad); end
`else
    checks++; if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL star_pulses: got %0d want 1", pulse_cnt - p0); end
`endif
  endtask

  task automatic test_ghost;
    int p0, chg, tr, tf;
    logic [2:0] last;
    p0 = pulse_cnt; chg = 0; last = col_out;
    keys[0][0] = 1'b1; keys[2][0] = 1'b1;
    for (int i = 0; i < 60; i++) begin tick(); if (col_out !== last) chg++; last = col_out; end
    keys = '0;
    tick(5);
    checks++; if (pulse_cnt != p0) begin errors++; $display("FAIL ghost_pulses: got %0d want 0", pulse_cnt - p0); end
    checks++; if (chg < 12) begin errors++; $display("FAIL ghost_scan: got %0d col changes want >=12", chg); end
    p0 = pulse_cnt;
    do_press(0, 0, 1'b0, 10, tr, tf);
    checks++; if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL one_pulses: got %0d want 1", pulse_cnt - p0); end
    checks++; if (pulse_code !== 4'b0001) begin errors++; $display("FAIL one_code: got %b want 0001", pulse_code); end
  endtask

  task automatic test_reset_mid;
    bit ok; int p0;
    wait_col(3'b101, ok);
    keys[2][2] = 1'b1;
    wait_col(3'b011, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst9_wait_col2: col %b", col_out); end
    tick(6);
    checks++; if (S_Row !== 1'b0) begin errors++; $display("FAIL rst9_pre_srow: got %b want 0", S_Row); end
    p0 = pulse_cnt;
    reset_1 = 1'b1; keys = '0;
    tick();
    checks++; if (col_out !== 3'b110) begin errors++; $display("FAIL rst9_col: got %b want 110", col_out); end
    checks++; if (Code_1 !== 4'b0000) begin errors++; $display("FAIL rst9_code: got %b want 0000", Code_1); end
    checks++; if (S_Row !== 1'b0) begin errors++; $display("FAIL rst9_srow: got %b want 0", S_Row); end
    reset_1 = 1'b0;
    tick(40);
    checks++; if (pulse_cnt != p0) begin errors++; $display("FAIL rst9_pulses: got %0d want 0", pulse_cnt - p0); end
  endtask

  task automatic test_random_keys;
    int r, c, p0, tr, tf;
    for (int it = 0; it < 8; it++) begin
      r = $urandom_range(0, 3); c = $urandom_range(0, 2);
      p0 = pulse_cnt;
      do_press(r, c, 1'($urandom_range(0, 1)), $urandom_range(5, 25), tr, tf);
      checks++; if (tr < 0 || tf < 0) begin errors++; $display("FAIL rand%0d_timeout: rise %0d fall %0d", it, tr, tf); end
      checks++;
      if (pulse_cnt - p0 != 1 || pulse_code !== ref_code(r, c)) begin
        errors++; $display("FAIL rand%0d_key r%0d c%0d: got %0d pulses code %b want 1 code %b",
                           it, r, c, pulse_cnt - p0, pulse_code, ref_code(r, c));
      end
    end
  endtask

  task automatic test_pulse_shape;
    checks++; if (wide_pulse != 0) begin errors++; $display("FAIL valid_width: %0d wide pulses want 0", wide_pulse); end
    checks++; if (code_unstable != 0) begin errors++; $display("FAIL code_setup: %0d pulses with changing code want 0", code_unstable); end
    checks++; if (valid_in_reset != 0) begin errors++; $display("FAIL valid_in_reset: got %0d want 0", valid_in_reset); end
  endtask

  initial begin
    keys = '0; reset_1 = 1'b1;
    test_reset();
    test_hash();
    test_bounce();
    test_hold_star();
    test_ghost();
    test_reset_mid();
    test_random_keys();
    test_pulse_shape();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
